// File: rtl/gshare_pred_if.sv
// Fetch/resolve bundle between the pipeline and the gshare predictor.
// The predictor side takes the slave modport.
interface gshare_pred_if #(
  parameter int IDX_BITS = 8
);
  logic [31:0]         f_pc;
  logic                pred;
  logic [IDX_BITS-1:0] f_idx;
  logic                ready;
  logic                u_valid;
  logic [IDX_BITS-1:0] u_idx;
  logic                u_taken;
  logic                u_pred;
  logic [31:0]         br_cnt;
  logic [31:0]         mispred_cnt;

  modport master (
    output f_pc, u_valid, u_idx, u_taken, u_pred,
    input  pred, f_idx, ready, br_cnt, mispred_cnt
  );

  modport slave (
    input  f_pc, u_valid, u_idx, u_taken, u_pred,
    output pred, f_idx, ready, br_cnt, mispred_cnt
  );
endinterface

// File: rtl/gshare_pred.sv
// gshare branch predictor: PC^history indexed saturating-counter table.
// Define BP_PERF_CNT_EN to build the branch/mispredict counters.
module gshare_pred #(
  parameter int IDX_BITS = 8,
  parameter int GHR_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int INIT_CTR = 2**CTR_BITS-1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  gshare_pred_if.slave bus
);

  localparam int DEPTH = 2**IDX_BITS;
  localparam logic [CTR_BITS-1:0] CMAX = '1;
  localparam logic [CTR_BITS-1:0] CINIT = CTR_BITS'(INIT_CTR);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_q;
  logic [IDX_BITS-1:0] ptr_q;
  logic [GHR_BITS-1:0] ghr_q;
  logic [GHR_BITS-1:0] ghr_d;
  logic [CTR_BITS-1:0] tbl_q [DEPTH];
  logic [CTR_BITS-1:0] ctr_old;
  logic [CTR_BITS-1:0] ctr_d;
  logic [IDX_BITS-1:0] idx;
  logic                rdy;
  logic                upd;
  logic                unused_bits;

  assign rdy = (state_q == IDLE);
  assign upd = bus.u_valid & rdy & ~clr;
  assign idx = bus.f_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);

  assign bus.ready = rdy;
  assign bus.f_idx = idx;
  assign bus.pred  = rdy & tbl_q[idx][CTR_BITS-1];

  // Truncating the concatenation drops the oldest history bit.
  assign ghr_d = GHR_BITS'({ghr_q, bus.u_taken});

  assign unused_bits = ^{bus.f_pc[31:IDX_BITS+2], bus.f_pc[1:0], bus.u_pred};

  always_comb begin
    ctr_old = tbl_q[bus.u_idx];
    ctr_d   = ctr_old;
    unique case (1'b1)
      bus.u_taken && (ctr_old != CMAX): ctr_d = ctr_old + 1'b1;
      !bus.u_taken && (ctr_old != '0):  ctr_d = ctr_old - 1'b1;
      default: ;
    endcase
  end

  // Table has no reset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (state_q == SWEEP) begin
      tbl_q[ptr_q] <= CINIT;
    end else if (upd) begin
      tbl_q[bus.u_idx] <= ctr_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
      ghr_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            ghr_q   <= '0;
          end else if (upd) begin
            ghr_q <= ghr_d;
          end
        end
        SWEEP: begin
          if (clr) begin
            ptr_q <= '0;
            ghr_q <= '0;
          end else if (ptr_q == '1) begin
            state_q <= IDLE;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: state_q <= SWEEP;
      endcase
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] br_q;
  logic [31:0] mis_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      br_q  <= '0;
      mis_q <= '0;
    end else if (upd) begin
      br_q <= br_q + 32'd1;
      if (bus.u_pred != bus.u_taken) begin
        mis_q <= mis_q + 32'd1;
      end
    end
  end

  assign bus.br_cnt      = br_q;
  assign bus.mispred_cnt = mis_q;
`else
  assign bus.br_cnt      = '0;
  assign bus.mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_gshare_pred.sv
// Randomized + directed bench for gshare_pred with an abstract table model.
// Also checks a tiny 16-entry, 1-bit-history, 1-bit-counter instance.
module tb_gshare_pred;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clr = 1'b0;
  logic clr2 = 1'b0;

  always #5 clk = ~clk;

  gshare_pred_if #(.IDX_BITS(8)) bus ();
  gshare_pred_if #(.IDX_BITS(4)) bus2 ();

  gshare_pred u_dut (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .bus  (bus)
  );

  gshare_pred #(
    .IDX_BITS(4),
    .GHR_BITS(1),
    .CTR_BITS(1)
  ) u_dut2 (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr2),
    .bus  (bus2)
  );

  int          m_tbl [256];
  int          m_ghr;
  bit          m_rdy;
  int          m_left;
  int unsigned m_br;
  int unsigned m_mis;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] e_cnt(input int unsigned v);
`ifdef BP_PERF_CNT_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic m_fill();
    foreach (m_tbl[i]) m_tbl[i] = 3;
  endtask

  // One cycle: drive at negedge, check, apply model at posedge.
  task automatic cyc(input logic [31:0] pc, input bit v,
                     input logic [7:0] idx, input bit t,
                     input bit p, input bit c);
    logic [7:0] ei;
    bit acc;
    bus.f_pc = pc;
    bus.u_valid = v;
    bus.u_idx = idx;
    bus.u_taken = t;
    bus.u_pred = p;
    clr = c;
    #1;
    ei = pc[9:2] ^ 8'(m_ghr);
    chk("f_idx", bus.f_idx, ei);
    chk("pred", bus.pred, (m_rdy && m_tbl[ei] >= 2) ? 1 : 0);
    chk("ready", bus.ready, m_rdy);
    chk("br_cnt", bus.br_cnt, e_cnt(m_br));
    chk("mispred_cnt", bus.mispred_cnt, e_cnt(m_mis));
    @(posedge clk);
    acc = m_rdy && v && !c;
    if (m_rdy && c) begin
      m_rdy = 0;
      m_left = 256;
      m_ghr = 0;
    end else if (!m_rdy) begin
      if (c) begin
        m_left = 256;
        m_ghr = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_rdy = 1;
          m_fill();
        end
      end
    end
    if (acc) begin
      if (t) m_tbl[idx] = (m_tbl[idx] == 3) ? 3 : m_tbl[idx] + 1;
      else   m_tbl[idx] = (m_tbl[idx] == 0) ? 0 : m_tbl[idx] - 1;
      m_ghr = (m_ghr * 2 + int'(t)) % 256;
      m_br++;
      if (p != t) m_mis++;
    end
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int cnt;
    int cnt2;
    int pbad;
    int n;
    int unsigned brb;
    int unsigned mb;
    logic [31:0] r;
    total = 0;
    bad = 0;
    bus.f_pc = '0;
    bus.u_valid = 1'b0;
    bus.u_idx = '0;
    bus.u_taken = 1'b0;
    bus.u_pred = 1'b0;
    bus2.f_pc = '0;
    bus2.u_valid = 1'b0;
    bus2.u_idx = '0;
    bus2.u_taken = 1'b0;
    bus2.u_pred = 1'b0;

    #12;
    chk("rst_ready", bus.ready, 0);
    chk("rst_pred", bus.pred, 0);
    chk("rst_br", bus.br_cnt, 0);
    chk("rst_mis", bus.mispred_cnt, 0);
    chk("rst_ready2", bus2.ready, 0);

    @(negedge clk);
    rstn = 1'b1;
    cnt = 0;
    cnt2 = 0;
    pbad = 0;
    for (int k = 0; k < 400; k++) begin
      bus.f_pc = $urandom;
      bus2.f_pc = '0;
      #1;
      if (!bus.ready) begin
        cnt++;
        if (bus.pred !== 1'b0) pbad++;
      end
      if (!bus2.ready) begin
        cnt2++;
        if (bus2.pred !== 1'b0) pbad++;
      end
      if (bus.ready && bus2.ready) break;
      @(negedge clk);
    end
    chk("init_cycles", cnt, 256);
    chk("init_cycles2", cnt2, 16);
    chk("pred_low_in_sweep", pbad, 0);
    m_rdy = 1;
    m_ghr = 0;
    m_br = 0;
    m_mis = 0;
    m_fill();

    for (int k = 0; k < 4; k++) cyc($urandom, 0, 0, 0, 0, 0);

    for (int k = 0; k < 4; k++) cyc($urandom, 1, 8'h05, 0, 1, 0);
    cyc(32'h14, 0, 0, 0, 0, 0);
    chk("idx5_sat_pred", bus.pred, 0);

    cyc($urandom, 1, 8'h10, 1, 1, 0);
    cyc($urandom, 1, 8'h11, 1, 1, 0);
    cyc($urandom, 1, 8'h12, 0, 0, 0);
    cyc(32'h14, 0, 0, 0, 0, 0);
    chk("ghr6_f_idx", bus.f_idx, 8'h03);

    for (int k = 0; k < 500; k++) begin
      r = $urandom;
      cyc($urandom, r[0], r[1] ? 8'(r[10:8]) : 8'(r[31:24]),
          r[2], r[3], r[23:17] == 7'd0);
    end

    n = 0;
    while (!m_rdy && n < 400) begin
      cyc($urandom, 0, 0, 0, 0, 0);
      n++;
    end
    cyc($urandom, 0, 0, 0, 0, 1);
    for (int k = 0; k < 100; k++) begin
      r = $urandom;
      cyc($urandom, 1, 8'(r[7:0]), r[8], r[9], 0);
    end
    brb = m_br;
    cyc($urandom, 0, 0, 0, 0, 1);
    n = 0;
    while (!bus.ready && n < 400) begin
      r = $urandom;
      cyc($urandom, 1, 8'(r[7:0]), r[8], r[9], 0);
      n++;
    end
    chk("clr_sweep_len", n, 256);
    chk("sweep_drop_br", bus.br_cnt, e_cnt(brb));
    bus.f_pc = '0;
    #1;
    chk("sweep_drop_ghr", bus.f_idx, 0);

    brb = m_br;
    mb = m_mis;
    for (int k = 0; k < 10; k++) begin
      r = $urandom;
      cyc($urandom, 1, 8'(r[7:0]), r[8], (k < 3) ? ~r[8] : r[8], 0);
    end
    chk("perf_br10", bus.br_cnt, e_cnt(brb + 10));
    chk("perf_mis3", bus.mispred_cnt, e_cnt(mb + 3));

    bus2.f_pc = '0;
    #1;
    chk("d2_pred_init", bus2.pred, 1);
    chk("d2_idx0", bus2.f_idx, 0);
    bus2.u_valid = 1'b1;
    bus2.u_idx = 4'h0;
    bus2.u_taken = 1'b0;
    @(posedge clk);
    #1;
    bus2.u_valid = 1'b0;
    @(negedge clk);
    chk("d2_pred_flip", bus2.pred, 0);
    chk("d2_ghr0", bus2.f_idx, 0);
    bus2.u_valid = 1'b1;
    bus2.u_idx = 4'h3;
    bus2.u_taken = 1'b1;
    @(posedge clk);
    #1;
    bus2.u_valid = 1'b0;
    @(negedge clk);
    chk("d2_ghr1_idx", bus2.f_idx, 4'h1);
    chk("d2_ghr1_pred", bus2.pred, 1);
    bus2.f_pc = 32'h4;
    #1;
    chk("d2_idx_xor", bus2.f_idx, 4'h0);
    chk("d2_pred_xor", bus2.pred, 0);
    bus2.u_valid = 1'b1;
    bus2.u_idx = 4'h9;
    bus2.u_taken = 1'b0;
    @(posedge clk);
    #1;
    bus2.u_valid = 1'b0;
    @(negedge clk);
    chk("d2_ghr_last", bus2.f_idx, 4'h1);
    bus2.f_pc = 32'h24;
    #1;
    chk("d2_pred9", bus2.pred, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
